// File: rtl/ps2_key_tracker.sv
`timescale 1ns/1ps
// PS/2 set-2 receiver that keeps a held-key bitmap for the eight game keys
// (W S A D J K L SPACE) from make/break codes, plus per-byte debug strobes.
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nx;
    logic          clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic          fe, tmo_hit;
    logic [7:0]    shift, shift_nx;
    logic [2:0]    cnt, cnt_nx;
    logic          par, par_nx;
    logic          good_nx, err_nx;
    logic [TW-1:0] tmo;
    logic          brk, ext;

    // Sync flops reset to the idle-high bus level so reset release makes no edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fe      = clk_prev & ~clk_s2;
    assign tmo_hit = (state != IDLE) && (tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmo <= '0;
        else if (fe || state == IDLE) tmo <= '0;
        else tmo <= tmo + TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shift <= 8'h00;
            cnt   <= 3'd0;
            par   <= 1'b0;
        end else begin
            state <= state_nx;
            shift <= shift_nx;
            cnt   <= cnt_nx;
            par   <= par_nx;
        end
    end

    // A falling edge always takes precedence over an expiring timeout
    always_comb begin
        state_nx = state;
        shift_nx = shift;
        cnt_nx   = cnt;
        par_nx   = par;
        good_nx  = 1'b0;
        err_nx   = 1'b0;
        if (fe) begin
            case (state)
                IDLE: if (!dat_s2) begin
                    state_nx = DATA;
                    cnt_nx   = 3'd0;
                end
                DATA: begin
                    shift_nx = {dat_s2, shift[7:1]};
                    cnt_nx   = cnt + 3'd1;
                    if (cnt == 3'd7) state_nx = PARITY;
                end
                PARITY: begin
                    par_nx   = dat_s2;
                    state_nx = STOP;
                end
                STOP: begin
                    if ((^{shift, par}) && dat_s2) good_nx = 1'b1;
                    else err_nx = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (tmo_hit) begin
            err_nx   = 1'b1;
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            scan_code  <= 8'h00;
        end else begin
            code_valid <= good_nx;
            frame_err  <= err_nx;
            if (good_nx) scan_code <= shift;
        end
    end

    // Decoder: prefixes arm flags, acks are transparent, 00/FF flush everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key <= 8'h00;
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (frame_err) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (code_valid) begin
            case (scan_code)
                8'hE0: ext <= 1'b1;
                8'hF0: brk <= 1'b1;
                8'hFA, 8'hAA, 8'hEE, 8'hFE: ;
                8'h00, 8'hFF: begin
                    key <= 8'h00;
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
                default: begin
                    if (!ext) begin
                        case (scan_code)
                            8'h1D: key[7] <= ~brk;
                            8'h1B: key[6] <= ~brk;
                            8'h1C: key[5] <= ~brk;
                            8'h23: key[4] <= ~brk;
                            8'h3B: key[3] <= ~brk;
                            8'h42: key[2] <= ~brk;
                            8'h4B: key[1] <= ~brk;
                            8'h29: key[0] <= ~brk;
                            default: ;
                        endcase
                    end
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_key_tracker.sv
`timescale 1ns/1ps
// Scoreboard bench: each frame pushes its expected strobe and resulting bitmap;
// a monitor pops and compares whenever code_valid or frame_err fires.
module tb_ps2_key_tracker;
    localparam int TMO  = 200;
    localparam int HALF = 10;

    logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] key, scan_code;
    logic       code_valid, frame_err;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key(key), .scan_code(scan_code), .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [7:0] key;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b);
        ps2_data = b;
        wait_clks(HALF);
        ps2_clk = 1'b0;
        wait_clks(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit stop,
                         input bit is_err, input logic [7:0] exp_key);
        exp_t e;
        e.is_err = is_err;
        e.code   = b;
        e.key    = exp_key;
        q.push_back(e);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out((~^b) ^ bad_par);
        bit_out(stop);
        ps2_data = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic good(input logic [7:0] b, input logic [7:0] exp_key);
        frame(b, 1'b0, 1'b1, 1'b0, exp_key);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (code_valid || frame_err) begin
                check8("strobe_exclusive", {7'd0, code_valid & frame_err}, 8'h00);
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got cv=%b err=%b expected none", code_valid, frame_err);
                end else begin
                    e = q.pop_front();
                    check8("strobe_kind", {7'd0, frame_err}, {7'd0, e.is_err});
                    if (!e.is_err) check8("scan_code", scan_code, e.code);
                    @(negedge clk);
                    check8("key", key, e.key);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

    initial begin : stim
        wait_clks(3);
        check8("reset_key", key, 8'h00);
        check8("reset_scan", scan_code, 8'h00);
        check8("reset_cv", {7'd0, code_valid}, 8'h00);
        check8("reset_err", {7'd0, frame_err}, 8'h00);
        reset = 1'b0;
        wait_clks(5);

        good(8'h1D, 8'h80);
        good(8'hF0, 8'h80);
        good(8'h1D, 8'h00);
        good(8'h29, 8'h01);
        good(8'h1D, 8'h81);
        good(8'h1C, 8'hA1);
        good(8'h29, 8'hA1);
        good(8'hF0, 8'hA1);
        good(8'h1C, 8'h81);
        good(8'hE0, 8'h81);
        good(8'h1D, 8'h81);
        good(8'h00, 8'h00);
        good(8'h4B, 8'h02);
        // A pending break must be dropped by a bad frame
        good(8'hF0, 8'h02);
        frame(8'h1D, 1'b1, 1'b1, 1'b1, 8'h02);
        good(8'h4B, 8'h02);
        frame(8'h1D, 1'b0, 1'b0, 1'b1, 8'h02);

        // Truncated frame: start + 3 data bits, then bus idles
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.code   = 8'h00;
            e.key    = 8'h02;
            q.push_back(e);
        end
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        ps2_data = 1'b1;
        wait_clks(TMO + 20);
        good(8'h1B, 8'h42);

        // Ack bytes between F0 and the key code must not cancel the break
        good(8'hF0, 8'h42);
        good(8'hFA, 8'h42);
        good(8'h4B, 8'h40);

        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(i[0]);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check8("midreset_key", key, 8'h00);
        check8("midreset_scan", scan_code, 8'h00);
        check8("midreset_cv", {7'd0, code_valid}, 8'h00);
        check8("midreset_err", {7'd0, frame_err}, 8'h00);
        ps2_data = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(5);
        good(8'h42, 8'h04);

        wait_clks(50);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expected: got %0d unmatched expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
